// File: rtl/fifo_uart_tx.sv
// Drain stage for the synchronous FIFO: pops one word at a time and sends it
// as a UART frame (start bit, LSB-first data, STOP_BITS stop bits).
//
// state | meaning
// IDLE  | line high, waiting for tx_enable && !fifo_empty
// FETCH | fifo_r_en high for one clock
// LOAD  | FIFO read data valid, captured into shift_reg
// START | start bit (line low)
// DATA  | data bits, LSB first
// STOP  | stop bit(s) (line high), frame_done on the last clock
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    input  logic                  tx_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [SW-1:0]         stop_cnt, stop_cnt_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  tx_nxt;
    logic                  bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            stop_cnt  <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            stop_cnt <= stop_cnt_nxt;
            tx       <= tx_nxt;
            if (state == LOAD) begin
                shift_reg <= fifo_data;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        stop_cnt_nxt = stop_cnt;
        fifo_r_en    = 1'b0;
        frame_done   = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                fifo_r_en = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt      = '0;
                idx_nxt      = '0;
                stop_cnt_nxt = '0;
                state_nxt    = START;
            end
            START: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            STOP: begin
                cnt_nxt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        frame_done   = 1'b1;
                        stop_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered, so it is driven from the state being entered
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_reg[idx_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues expected words, a monitor
// decodes every frame cycle by cycle from each pop.
module tb_fifo_uart_tx;
    typedef struct {
        logic [7:0] d;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic       sel;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] f_data = 8'h00;
    logic       f_empty = 1'b1;
    logic       r_en1, tx1, busy1, fd1;
    logic       r_en2, tx2, busy2, fd2;
    logic       empty1, empty2;
    logic       m_r_en, m_tx, m_busy, m_fd;

    logic [7:0] fq[$];
    exp_t       exp_q[$];
    int         pop_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         pop_count = 0;
    int         last_pop_cyc = 0;
    bit         mon_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // only the selected DUT sees a non-empty FIFO
    assign empty1 = sel ? 1'b1 : f_empty;
    assign empty2 = sel ? f_empty : 1'b1;
    assign m_r_en = sel ? r_en2 : r_en1;
    assign m_tx   = sel ? tx2 : tx1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_fd   = sel ? fd2 : fd1;

    always @(posedge clk) begin
        if (m_r_en && fq.size() > 0) f_data <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        f_empty <= (fq.size() == 0);
    end

    fifo_uart_tx dut (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_data(f_data),
        .fifo_r_en(r_en1), .tx_enable(tx_enable), .tx(tx1), .busy(busy1),
        .frame_done(fd1)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(f_data),
        .fifo_r_en(r_en2), .tx_enable(tx_enable), .tx(tx2), .busy(busy2),
        .frame_done(fd2)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(input logic [7:0] d, input bit ab);
        exp_t e;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        e.d     = d;
        e.abort = ab;
        exp_q.push_back(e);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(exp_q.size() == 0 && !mon_busy && !m_busy) && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(name, t < 3000, 1);
    endtask

    task automatic wait_pop(input int pc0);
        int t = 0;
        while (pop_count <= pc0 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("pop_timeout", t < 500, 1);
    endtask

    // Pop at cycle P, LOAD at P+1, start bit from P+2, frame_done at P+1+L.
    task automatic run_frame();
        exp_t e;
        int   cpb, len, bitpos;
        bit   ab = 1'b0;
        logic exp_tx;
        cpb = sel ? 2 : 4;
        len = sel ? 2 * (1 + 8 + 2) : 4 * (1 + 8 + 1);
        mon_busy = 1'b1;
        pop_q.push_back(cyc);
        last_pop_cyc = cyc;
        pop_count++;
        if (exp_q.size() == 0) begin
            chk("unexpected_pop", 1, 0);
            e.d = 8'h00;
            e.abort = 1'b0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("pop_while_empty", f_empty, 0);
        chk("fetch_tx", m_tx, 1);
        chk("fetch_busy", m_busy, 1);
        @(negedge clk);
        if (!rst) ab = 1'b1;
        else begin
            chk("load_r_en", m_r_en, 0);
            chk("load_tx", m_tx, 1);
            chk("load_busy", m_busy, 1);
        end
        for (int k = 0; k < len && !ab; k++) begin
            @(negedge clk);
            if (!rst) ab = 1'b1;
            else begin
                bitpos = k / cpb;
                if (bitpos == 0) exp_tx = 1'b0;
                else if (bitpos <= 8) exp_tx = e.d[bitpos-1];
                else exp_tx = 1'b1;
                chk("frame_tx", m_tx, exp_tx);
                chk("frame_done", m_fd, (k == len - 1));
                chk("frame_busy", m_busy, 1);
                chk("frame_r_en", m_r_en, 0);
            end
        end
        if (!ab) begin
            @(negedge clk);
            chk("post_busy", m_busy, 0);
            chk("post_tx", m_tx, 1);
        end
        chk("abort", ab, e.abort);
        mon_busy = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst && m_r_en) run_frame();
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pq0, pc0, target, bad;
        rst = 1'b1; tx_enable = 1'b1; sel = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        #3 rst = 1'b0;

        push(8'hA5, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", m_tx, 1);
            chk("rst_r_en", m_r_en, 0);
            chk("rst_busy", m_busy, 0);
            chk("rst_frame_done", m_fd, 0);
        end
        rst = 1'b1;
        wait_idle("single_done");

        tx_enable = 1'b0;
        pq0 = pop_q.size();
        push(8'h3C, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h00, 1'b0);
        tx_enable = 1'b1;
        wait_idle("b2b_done");
        chk("b2b_pops", pop_q.size() - pq0, 3);
        if (pop_q.size() - pq0 == 3) begin
            chk("b2b_spacing1", pop_q[pq0+1] - pop_q[pq0], 43);
            chk("b2b_spacing2", pop_q[pq0+2] - pop_q[pq0+1], 43);
        end
        repeat (20) @(negedge clk);
        chk("no_pop_after_empty", pop_q.size() - pq0, 3);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_r_en || m_busy || !m_tx) bad++;
        end
        chk("empty_idle", bad, 0);

        tx_enable = 1'b0;
        push(8'h5A, 1'b0);
        push(8'h77, 1'b0);
        pc0 = pop_count;
        tx_enable = 1'b1;
        wait_pop(pc0);
        repeat (10) @(posedge clk);
        #1 tx_enable = 1'b0;
        bad = 0;
        while (mon_busy && bad < 200) begin
            @(negedge clk);
            #1;
            bad++;
        end
        repeat (30) @(negedge clk);
        chk("gated_no_pop", pop_count - pc0, 1);
        chk("gated_fifo_held", f_empty, 0);
        tx_enable = 1'b1;
        wait_idle("gated_resume");

        tx_enable = 1'b0;
        push(8'hC3, 1'b1);
        push(8'h3A, 1'b0);
        pc0 = pop_count;
        tx_enable = 1'b1;
        wait_pop(pc0);
        target = last_pop_cyc + 19;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < target);
        chk("pre_rst_tx_bit3", m_tx, 0);
        rst = 1'b0;
        #1;
        chk("midrst_tx", m_tx, 1);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_frame_done", m_fd, 0);
        chk("midrst_r_en", m_r_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_idle("rst_recover");
        chk("rst_recover_pops", pop_count - pc0, 2);

        tx_enable = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        push(8'h81, 1'b0);
        tx_enable = 1'b1;
        wait_idle("variant_done");
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
